// File: rtl/pe_stream_pkg.sv
// Shared types for the PE bit-serial transmit driver.
// Holds the controller state encoding and the default serial word width.
package pe_stream_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LUPD,
        RELAX,
        RUPD,
        READ,
        RDONE
    } state_t;

endpackage

// File: rtl/pe_stream_driver_piso.sv
// Parallel-in serial-out shifter, MSB first; one per stencil direction.
// Load takes priority over shift; reset clears the register.
module pe_piso
    import pe_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/pe_stream_driver.sv
// Serialises one stencil word set into a PE, sequences load/relax sweeps and (with
// PE_DRV_READBACK_EN) reads the serial solution back; accept-to-out_valid is
// (WIDTH+1)*(iters+2) busy cycles; in_ready only in IDLE, requests while busy are ignored.
module pe_stream_driver
    import pe_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ITER_W = 4
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_left,
    input  logic [WIDTH-1:0]  in_top,
    input  logic [WIDTH-1:0]  in_right,
    input  logic [WIDTH-1:0]  in_down,
    input  logic [ITER_W-1:0] in_iters,
    output logic              pe_mode,
    output logic              pe_left,
    output logic              pe_top,
    output logic              pe_right,
    output logic              pe_down,
    output logic              pe_update,
    output logic              pe_read,
    input  logic              pe_solution,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_solution,
    output logic              busy
);

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PE_DRV_READBACK_EN
    localparam state_t AFTER_SWEEPS = READ;
`else
    localparam state_t AFTER_SWEEPS = IDLE;
`endif

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ITER_W-1:0]   sweep_cnt;
    logic                accept;
    logic                phase_end;
    logic                timed_phase;
    logic [3:0]          msb;

    assign accept      = in_valid & in_ready;
    assign phase_end   = (bit_cnt == LAST);
    assign timed_phase = (state == LOAD) || (state == RELAX) || (state == READ);

    pe_piso #(.WIDTH(WIDTH)) u_piso_left (
        .clk(clka), .rst(rst), .load(accept), .shift(state == LOAD),
        .din(in_left), .msb(msb[0])
    );
    pe_piso #(.WIDTH(WIDTH)) u_piso_top (
        .clk(clka), .rst(rst), .load(accept), .shift(state == LOAD),
        .din(in_top), .msb(msb[1])
    );
    pe_piso #(.WIDTH(WIDTH)) u_piso_right (
        .clk(clka), .rst(rst), .load(accept), .shift(state == LOAD),
        .din(in_right), .msb(msb[2])
    );
    pe_piso #(.WIDTH(WIDTH)) u_piso_down (
        .clk(clka), .rst(rst), .load(accept), .shift(state == LOAD),
        .din(in_down), .msb(msb[3])
    );

    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            sweep_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Counter restarts at every phase boundary so phases never share a count.
            if (timed_phase && !phase_end) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end else begin
                bit_cnt <= '0;
            end
            if (accept) begin
                sweep_cnt <= in_iters;
            end else if (state == RUPD) begin
                sweep_cnt <= sweep_cnt - ITER_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        pe_mode   = 1'b0;
        pe_update = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOAD;
            end
            LOAD: begin
                pe_mode = 1'b1;
                if (phase_end) state_nxt = LUPD;
            end
            LUPD: begin
                pe_mode   = 1'b1;
                pe_update = 1'b1;
                state_nxt = (sweep_cnt != '0) ? RELAX : AFTER_SWEEPS;
            end
            RELAX: begin
                if (phase_end) state_nxt = RUPD;
            end
            RUPD: begin
                // Decision uses the count as it will be after this cycle's decrement.
                pe_update = 1'b1;
                state_nxt = (sweep_cnt != ITER_W'(1)) ? RELAX : AFTER_SWEEPS;
            end
`ifdef PE_DRV_READBACK_EN
            READ: begin
                if (phase_end) state_nxt = RDONE;
            end
            RDONE: begin
                state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign pe_left  = (state == LOAD) & msb[0];
    assign pe_top   = (state == LOAD) & msb[1];
    assign pe_right = (state == LOAD) & msb[2];
    assign pe_down  = (state == LOAD) & msb[3];

`ifdef PE_DRV_READBACK_EN
    logic [WIDTH-1:0] sipo;

    assign pe_read   = (state == READ);
    assign out_valid = (state == RDONE);

    // The word is captured on the READ->RDONE edge so it is already stable
    // during the RDONE cycle that carries out_valid.
    always_ff @(posedge clka) begin
        if (rst) begin
            sipo         <= '0;
            out_solution <= '0;
        end else if (state == READ) begin
            sipo <= {sipo[WIDTH-2:0], pe_solution};
            if (phase_end) out_solution <= {sipo[WIDTH-2:0], pe_solution};
        end
    end
`else
    logic unused_solution;

    assign unused_solution = pe_solution;
    assign pe_read         = 1'b0;
    assign out_valid       = 1'b0;
    assign out_solution    = '0;
`endif

endmodule
